mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single RAM port among the icache and dcache of every core.
//  Sits between the per-core caches (cache_control side) and the RAM model.
//  Grants one requester at a time and holds the grant while its request stays
//  asserted, so a dcache block fill/writeback burst is never interleaved.
//  Arbitration: dcache requests beat icache requests; round-robin among cores
//  within each class.
// PARAMETERS
//  CPUS      2   number of cores; requesters = 2*CPUS
//  MAX_IDLE  64  cycles a grant may see no ACCESS before the timeout flag sets
// PORTS
//  CLK        in   1          clock, rising edge
//  nRST       in   1          asynchronous reset, active low
//  iREN       in   CPUS       icache read request, per core
//  iaddr      in   CPUS*32    icache word address, per core
//  iwait      out  CPUS       1 = icache must stall; 0 for exactly one cycle per beat
//  iload      out  CPUS*32    icache read data (ramload broadcast)
//  dREN       in   CPUS       dcache read request, per core
//  dWEN       in   CPUS       dcache write request, per core
//  daddr      in   CPUS*32    dcache word address, per core
//  dstore     in   CPUS*32    dcache write data, per core
//  dwait      out  CPUS       1 = dcache must stall; 0 for exactly one cycle per beat
//  dload      out  CPUS*32    dcache read data (ramload broadcast)
//  ramREN     out  1          RAM read enable
//  ramWEN     out  1          RAM write enable
//  ramaddr    out  32         RAM address
//  ramstore   out  32         RAM write data
//  ramload    in   32         RAM read data
//  ramstate   in   2          ramstate_t: FREE, BUSY, ACCESS, ERROR
//  timeout    out  1          sticky: a grant exceeded MAX_IDLE cycles without ACCESS
// BEHAVIOUR
//  Reset (async): state=IDLE; both rr pointers=0; ramREN=ramWEN=0; ramaddr=0;
//    ramstore=0; all iwait/dwait=1; timeout=0; idle counter=0.
//    Applies instantly mid-burst: RAM enables drop without waiting for CLK.
//  States:
//    IDLE  - no owner; RAM enables 0; all waits 1. If any request is present,
//            latch the winner into the owner register and go to GRANT.
//    GRANT - owner's signals drive the RAM combinationally.
//            Stay in GRANT while the owner's request is asserted.
//            When it deasserts, go to IDLE.
//  Latency: request seen in IDLE at edge N; RAM enables driven in cycle N+1.
//    After release there is one IDLE cycle before the next grant (dead cycle).
//  Winner selection (IDLE only):
//    - Any dREN|dWEN beats any iREN.
//    - Within a class, pick the first requesting core at or after that class's
//      pointer, wrapping CPUS-1 -> 0.
//    - On grant, the class pointer becomes (winner+1) mod CPUS.
//  Drive in GRANT:
//    - dcache owner: ramWEN=dWEN; ramREN=dREN & ~dWEN (write wins if both);
//      ramaddr=daddr; ramstore=dstore.
//    - icache owner: ramREN=1; ramWEN=0; ramaddr=iaddr; ramstore=0.
//  Waits: the owner's wait = (ramstate != ACCESS); every non-owner wait = 1.
//    ERROR and BUSY both stall. Same-cycle deassertion of the owner's request
//    releases it even if ramstate=ACCESS; that beat is not acknowledged.
//  iload/dload for all cores = ramload every cycle.
//  Timeout: counter resets on grant or on ACCESS and increments otherwise in
//    GRANT, saturating at MAX_IDLE. Reaching MAX_IDLE sets timeout until nRST.
//    The grant is not revoked.
//  Simultaneous requests from one core (dcache + icache): dcache wins;
//    icache keeps iwait=1 until its own grant.
// TESTING
//  1 Reset: nRST=0 mid-grant -> ramREN=ramWEN=0, all waits=1, timeout=0 without waiting for CLK.
//  2 Single iREN[0], iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles
//      -> ramREN=1, ramaddr=0x40 from cycle 1; iwait[0]=0 on the ACCESS cycle only.
//  3 dREN[0]+iREN[0]+iREN[1] together -> dcache0 granted first;
//      then icache0, then icache1 (rr order), one dead cycle between grants.
//  4 dWEN[1] 2-word burst (0x100, 0x104) while dREN[0] is pending
//      -> both writes complete before core0 is granted; no interleave.
//  5 dREN[0] and dREN[1] requesting continuously -> grants alternate 0,1,0,1.
//  6 Grant held with ramstate=BUSY for MAX_IDLE cycles -> timeout=1 and stays 1;
//      ACCESS still completes afterwards.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// mem_bus_arbiter_if : cache-side and RAM-side signals of the shared RAM port
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if #(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]      iREN;
    logic [CPUS*32-1:0]   iaddr;
    logic [CPUS-1:0]      iwait;
    logic [CPUS*32-1:0]   iload;
    logic [CPUS-1:0]      dREN;
    logic [CPUS-1:0]      dWEN;
    logic [CPUS*32-1:0]   daddr;
    logic [CPUS*32-1:0]   dstore;
    logic [CPUS-1:0]      dwait;
    logic [CPUS*32-1:0]   dload;
    logic                 ramREN;
    logic                 ramWEN;
    logic [31:0]          ramaddr;
    logic [31:0]          ramstore;
    logic [31:0]          ramload;
    logic [1:0]           ramstate;
    logic                 timeout;

    // Arbiter view
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
    );

    // Cache/RAM environment view
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter : shares one RAM port among all icaches/dcaches
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int CPUS     = 2,
    parameter int MAX_IDLE = 64
) (
    input  wire logic           CLK,
    input  wire logic           nRST,
    mem_bus_arbiter_if.master   bus
);
    localparam int         c_IDXW       = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int         c_CNTW       = $clog2(MAX_IDLE + 1);
    localparam logic [1:0] c_RAM_ACCESS = 2'd2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_own_d;
    logic [c_IDXW-1:0]   r_own_idx;
    logic [c_IDXW-1:0]   r_iptr;
    logic [c_IDXW-1:0]   r_dptr;
    logic [c_CNTW-1:0]   r_idle_cnt;
    logic [c_CNTW-1:0]   w_cnt_next;
    logic                r_timeout;

    logic [CPUS-1:0]     w_dreq;
    logic                w_any_d;
    logic                w_any_i;
    logic [c_IDXW-1:0]   w_dwin;
    logic [c_IDXW-1:0]   w_iwin;
    logic                w_grant;
    logic                w_own_req;
    logic                w_access;

    // First requester at or after ptr, wrapping.
    function automatic logic [c_IDXW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                                  input logic [c_IDXW-1:0] ptr);
        logic [c_IDXW-1:0] pick;
        logic              found;
        int                idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            idx = (int'(ptr) + k) % CPUS;
            if (!found && req[idx]) begin
                pick  = c_IDXW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [c_IDXW-1:0] idx_inc(input logic [c_IDXW-1:0] v);
        return (v == c_IDXW'(CPUS - 1)) ? '0 : v + 1'b1;
    endfunction

    assign w_dreq    = bus.dREN | bus.dWEN;
    assign w_any_d   = |w_dreq;
    assign w_any_i   = |bus.iREN;
    assign w_dwin    = rr_pick(w_dreq, r_dptr);
    assign w_iwin    = rr_pick(bus.iREN, r_iptr);
    assign w_grant   = (r_state == IDLE) && (w_any_d || w_any_i);
    assign w_own_req = r_own_d ? w_dreq[r_own_idx] : bus.iREN[r_own_idx];
    assign w_access  = (bus.ramstate == c_RAM_ACCESS);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_d || w_any_i) w_state_next = GRANT;
            GRANT:   if (!w_own_req)         w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Idle counter only advances while a grant is held without ACCESS.
    always_comb begin
        w_cnt_next = r_idle_cnt;
        if (w_grant || (r_state == GRANT && w_access))
            w_cnt_next = '0;
        else if (r_state == GRANT && r_idle_cnt != c_CNTW'(MAX_IDLE))
            w_cnt_next = r_idle_cnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_own_d    <= 1'b0;
            r_own_idx  <= '0;
            r_iptr     <= '0;
            r_dptr     <= '0;
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idle_cnt <= w_cnt_next;
            if (w_cnt_next == c_CNTW'(MAX_IDLE))
                r_timeout <= 1'b1;
            if (w_grant) begin
                r_own_d <= w_any_d;
                if (w_any_d) begin
                    r_own_idx <= w_dwin;
                    r_dptr    <= idx_inc(w_dwin);
                end else begin
                    r_own_idx <= w_iwin;
                    r_iptr    <= idx_inc(w_iwin);
                end
            end
        end
    end

    // RAM drive is purely combinational from the owner so reset drops it at once.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        if (r_state == GRANT) begin
            if (r_own_d) begin
                bus.ramWEN   = bus.dWEN[r_own_idx];
                bus.ramREN   = bus.dREN[r_own_idx] & ~bus.dWEN[r_own_idx];
                bus.ramaddr  = bus.daddr[32*int'(r_own_idx) +: 32];
                bus.ramstore = bus.dstore[32*int'(r_own_idx) +: 32];
                bus.dwait[r_own_idx] = ~(w_own_req & w_access);
            end else begin
                bus.ramREN   = 1'b1;
                bus.ramaddr  = bus.iaddr[32*int'(r_own_idx) +: 32];
                bus.iwait[r_own_idx] = ~(w_own_req & w_access);
            end
        end
    end

    assign bus.iload   = {CPUS{bus.ramload}};
    assign bus.dload   = {CPUS{bus.ramload}};
    assign bus.timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// tb_mem_bus_arbiter : cycle-vector and directed-sequence bench for the arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;
    localparam logic [1:0]  c_FREE = 2'd0;
    localparam logic [1:0]  c_BUSY = 2'd1;
    localparam logic [1:0]  c_ACC  = 2'd2;
    localparam logic [1:0]  c_ERR  = 2'd3;
    localparam logic [31:0] c_D0   = 32'hD000_0000;
    localparam logic [31:0] c_D1   = 32'hD000_0001;

    typedef struct {
        logic [1:0]  iren, dren, dwen, rs;
        logic [31:0] da1;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic [1:0]  iw, dw;
    } vec_t;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vq[$];

    mem_bus_arbiter_if #(.CPUS(2)) bus ();

    mem_bus_arbiter #(.CPUS(2), .MAX_IDLE(64)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] iren, input logic [1:0] dren, input logic [1:0] dwen,
                       input logic [1:0] rs, input logic [31:0] da1,
                       input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] store, input logic [1:0] iw, input logic [1:0] dw);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.da1 = da1;
        v.ren = ren; v.wen = wen; v.addr = addr; v.store = store; v.iw = iw; v.dw = dw;
        vq.push_back(v);
    endtask

    task automatic idle_vec(input logic [1:0] iren, input logic [1:0] dren,
                            input logic [1:0] dwen, input logic [31:0] da1);
        add(iren, dren, dwen, c_FREE, da1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11);
    endtask

    initial begin
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0; bus.ramstate = c_FREE;
        bus.iaddr = {32'h80, 32'h40};
        bus.daddr = {32'h0, 32'h200};
        bus.dstore = {c_D1, c_D0};
        bus.ramload = 32'hCAFE_F00D;

        // Icache0/dcache0/icache1 together: d0, then i0, then i1.
        idle_vec(2'b11, 2'b01, 2'b00, 32'h0);
        add(2'b11, 2'b01, 2'b00, c_ACC,  32'h0, 1, 0, 32'h200, c_D0, 2'b11, 2'b10);
        add(2'b11, 2'b00, 2'b00, c_FREE, 32'h0, 0, 0, 32'h200, c_D0, 2'b11, 2'b11);
        idle_vec(2'b11, 2'b00, 2'b00, 32'h0);
        add(2'b11, 2'b00, 2'b00, c_ACC,  32'h0, 1, 0, 32'h40, 32'h0, 2'b10, 2'b11);
        add(2'b10, 2'b00, 2'b00, c_FREE, 32'h0, 1, 0, 32'h40, 32'h0, 2'b11, 2'b11);
        idle_vec(2'b10, 2'b00, 2'b00, 32'h0);
        add(2'b10, 2'b00, 2'b00, c_ACC,  32'h0, 1, 0, 32'h80, 32'h0, 2'b01, 2'b11);
        add(2'b00, 2'b00, 2'b00, c_FREE, 32'h0, 1, 0, 32'h80, 32'h0, 2'b11, 2'b11);
        idle_vec(2'b00, 2'b00, 2'b00, 32'h0);
        // Single icache0 read with BUSY and ERROR stalls before ACCESS.
        idle_vec(2'b01, 2'b00, 2'b00, 32'h0);
        add(2'b01, 2'b00, 2'b00, c_BUSY, 32'h0, 1, 0, 32'h40, 32'h0, 2'b11, 2'b11);
        add(2'b01, 2'b00, 2'b00, c_ERR,  32'h0, 1, 0, 32'h40, 32'h0, 2'b11, 2'b11);
        add(2'b01, 2'b00, 2'b00, c_ACC,  32'h0, 1, 0, 32'h40, 32'h0, 2'b10, 2'b11);
        add(2'b00, 2'b00, 2'b00, c_FREE, 32'h0, 1, 0, 32'h40, 32'h0, 2'b11, 2'b11);
        idle_vec(2'b00, 2'b00, 2'b00, 32'h0);
        // dcache1 two-word write burst while dcache0 read waits.
        idle_vec(2'b00, 2'b01, 2'b10, 32'h100);
        add(2'b00, 2'b01, 2'b10, c_BUSY, 32'h100, 0, 1, 32'h100, c_D1, 2'b11, 2'b11);
        add(2'b00, 2'b01, 2'b10, c_ACC,  32'h100, 0, 1, 32'h100, c_D1, 2'b11, 2'b01);
        add(2'b00, 2'b01, 2'b10, c_BUSY, 32'h104, 0, 1, 32'h104, c_D1, 2'b11, 2'b11);
        add(2'b00, 2'b01, 2'b10, c_ACC,  32'h104, 0, 1, 32'h104, c_D1, 2'b11, 2'b01);
        add(2'b00, 2'b01, 2'b00, c_FREE, 32'h104, 0, 0, 32'h104, c_D1, 2'b11, 2'b11);
        idle_vec(2'b00, 2'b01, 2'b00, 32'h104);
        add(2'b00, 2'b01, 2'b00, c_ACC,  32'h104, 1, 0, 32'h200, c_D0, 2'b11, 2'b10);
        add(2'b00, 2'b00, 2'b00, c_FREE, 32'h104, 0, 0, 32'h200, c_D0, 2'b11, 2'b11);
        idle_vec(2'b00, 2'b00, 2'b00, 32'h104);
        // Both dcaches re-requesting: grants alternate 1,0,1,0.
        for (int n = 0; n < 4; n++) begin
            idle_vec(2'b00, 2'b11, 2'b00, 32'h104);
            if (n % 2 == 0) begin
                add(2'b00, 2'b11, 2'b00, c_ACC,  32'h104, 1, 0, 32'h104, c_D1, 2'b11, 2'b01);
                add(2'b00, 2'b01, 2'b00, c_FREE, 32'h104, 0, 0, 32'h104, c_D1, 2'b11, 2'b11);
            end else begin
                add(2'b00, 2'b11, 2'b00, c_ACC,  32'h104, 1, 0, 32'h200, c_D0, 2'b11, 2'b10);
                add(2'b00, (n == 3) ? 2'b00 : 2'b10, 2'b00, c_FREE, 32'h104,
                    0, 0, 32'h200, c_D0, 2'b11, 2'b11);
            end
        end
        idle_vec(2'b00, 2'b00, 2'b00, 32'h104);
        // dREN and dWEN together: write wins.
        idle_vec(2'b00, 2'b10, 2'b10, 32'h300);
        add(2'b00, 2'b10, 2'b10, c_ACC,  32'h300, 0, 1, 32'h300, c_D1, 2'b11, 2'b01);
        add(2'b00, 2'b00, 2'b00, c_FREE, 32'h300, 0, 0, 32'h300, c_D1, 2'b11, 2'b11);
        idle_vec(2'b00, 2'b00, 2'b00, 32'h300);

        // Reset state
        #2;
        chk("rst ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("rst ramaddr", bus.ramaddr, 32'h0);
        chk("rst iwait", 32'(bus.iwait), 32'h3);
        chk("rst dwait", 32'(bus.dwait), 32'h3);
        chk("rst timeout", 32'(bus.timeout), 32'h0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        foreach (vq[i]) begin
            @(negedge CLK);
            bus.iREN = vq[i].iren; bus.dREN = vq[i].dren; bus.dWEN = vq[i].dwen;
            bus.ramstate = vq[i].rs;
            bus.daddr = {vq[i].da1, 32'h200};
            #1;
            chk($sformatf("v%0d ramREN", i),   32'(bus.ramREN), 32'(vq[i].ren));
            chk($sformatf("v%0d ramWEN", i),   32'(bus.ramWEN), 32'(vq[i].wen));
            chk($sformatf("v%0d ramaddr", i),  bus.ramaddr,     vq[i].addr);
            chk($sformatf("v%0d ramstore", i), bus.ramstore,    vq[i].store);
            chk($sformatf("v%0d iwait", i),    32'(bus.iwait),  32'(vq[i].iw));
            chk($sformatf("v%0d dwait", i),    32'(bus.dwait),  32'(vq[i].dw));
            chk($sformatf("v%0d iload", i),    bus.iload[63:32], bus.ramload);
            chk($sformatf("v%0d dload", i),    bus.dload[31:0],  bus.ramload);
        end

        // Timeout: 64 idle grant cycles set the sticky flag, grant is kept.
        @(negedge CLK);
        bus.iREN = 2'b01; bus.dREN = '0; bus.dWEN = '0; bus.ramstate = c_BUSY;
        repeat (64) @(negedge CLK);
        #1;
        chk("to before limit", 32'(bus.timeout), 32'h0);
        @(negedge CLK);
        #1;
        chk("to at limit", 32'(bus.timeout), 32'h1);
        chk("to grant kept", 32'(bus.ramREN), 32'h1);
        chk("to iwait stall", 32'(bus.iwait), 32'h3);
        repeat (5) @(negedge CLK);
        bus.ramstate = c_ACC;
        #1;
        chk("to sticky", 32'(bus.timeout), 32'h1);
        chk("to access ack", 32'(bus.iwait), 32'h2);
        @(negedge CLK);
        bus.iREN = '0; bus.ramstate = c_FREE;
        @(negedge CLK);
        #1;
        chk("to idle sticky", 32'(bus.timeout), 32'h1);
        chk("to idle ramREN", 32'(bus.ramREN), 32'h0);

        // Asynchronous reset in the middle of a grant.
        bus.dWEN = 2'b01; bus.ramstate = c_BUSY;
        @(negedge CLK);
        #1;
        chk("ar granted", 32'(bus.ramWEN), 32'h1);
        #1 nRST = 1'b0;
        #1;
        chk("ar ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("ar ramREN", 32'(bus.ramREN), 32'h0);
        chk("ar dwait", 32'(bus.dwait), 32'h3);
        chk("ar iwait", 32'(bus.iwait), 32'h3);
        chk("ar timeout", 32'(bus.timeout), 32'h0);
        bus.dWEN = '0; bus.ramstate = c_FREE;
        @(negedge CLK);
        nRST = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
